// File: rtl/result_piso.sv
// Parallel-in serial-out drain for one systolic-array result row over a valid/ready stream.
// Optional macro RESULT_PISO_HOLD_EN adds a one-row holding register for overlapped loads.
module result_piso #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_COLS    = 4,
  parameter int unsigned COUNT_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_piso,
  input  logic                           load,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] par_in,
  output logic                           load_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic [COUNT_WIDTH-1:0]         beat_idx,
  output logic                           overrun
);

  localparam int unsigned ROW_W = NUM_COLS * DATA_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(NUM_COLS - 1);
  localparam logic ONE_COL = (NUM_COLS == 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t                 r_state;
  logic [ROW_W-1:0]       r_shift;
  logic [COUNT_WIDTH-1:0] r_beat;
  logic                   r_valid;
  logic                   r_last;
  logic                   r_overrun;

  logic w_xfer;
  logic w_xfer_last;
  logic w_load_ready;
  logic w_reject;

`ifdef RESULT_PISO_HOLD_EN
  logic [ROW_W-1:0] r_hold;
  logic             r_hold_valid;
`endif

  assign w_xfer      = r_valid & out_ready;
  assign w_xfer_last = w_xfer & r_last;

  // Ready in SHIFT depends on out_ready this cycle so a new row can follow with no bubble.
`ifdef RESULT_PISO_HOLD_EN
  assign w_load_ready = ~rst_piso & ((r_state == S_IDLE) | ~r_hold_valid | w_xfer_last);
`else
  assign w_load_ready = ~rst_piso & ((r_state == S_IDLE) | w_xfer_last);
`endif
  assign w_reject = ~rst_piso & load & ~w_load_ready;

  always_ff @(posedge clk) begin
    if (rst_piso) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_beat    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_overrun <= 1'b0;
`ifdef RESULT_PISO_HOLD_EN
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
`endif
    end else begin
      if (w_reject) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shift <= par_in;
            r_beat  <= '0;
            r_last  <= ONE_COL;
            r_valid <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_xfer_last) begin
`ifdef RESULT_PISO_HOLD_EN
            if (r_hold_valid) begin
              r_shift      <= r_hold;
              r_beat       <= '0;
              r_last       <= ONE_COL;
              r_hold_valid <= load;
              if (load) begin
                r_hold <= par_in;
              end
            end else
`endif
            if (load) begin
              r_shift <= par_in;
              r_beat  <= '0;
              r_last  <= ONE_COL;
            end else begin
              r_beat  <= '0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            // Word 0 always sits in the low bits; shift down on each accepted beat.
            if (w_xfer) begin
              r_shift <= r_shift >> DATA_WIDTH;
              r_beat  <= r_beat + COUNT_WIDTH'(1);
              r_last  <= ((r_beat + COUNT_WIDTH'(1)) == LAST_IDX);
            end
`ifdef RESULT_PISO_HOLD_EN
            if (load && !r_hold_valid) begin
              r_hold       <= par_in;
              r_hold_valid <= 1'b1;
            end
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign load_ready = w_load_ready;
  assign out_data   = r_shift[DATA_WIDTH-1:0];
  assign out_valid  = r_valid;
  assign out_last   = r_last;
  assign busy       = (r_state == S_SHIFT);
  assign beat_idx   = r_beat;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_result_piso.sv
// Directed self-checking bench for result_piso (default 16-bit x 4-column configuration).
module tb_result_piso;

  localparam int unsigned DW = 16;
  localparam int unsigned NC = 4;
  localparam int unsigned CW = 4;

  logic            clk;
  logic            rst_piso;
  logic            load;
  logic [NC*DW-1:0] par_in;
  logic            load_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            busy;
  logic [CW-1:0]   beat_idx;
  logic            overrun;

  int tests = 0;
  int fails = 0;

  localparam logic [NC*DW-1:0] ROW_A = 64'h0004_0003_0002_0001;
  localparam logic [NC*DW-1:0] ROW_B = 64'h0008_0007_0006_0005;
  localparam logic [NC*DW-1:0] ROW_C = 64'h000C_000B_000A_0009;

  result_piso #(.DATA_WIDTH(DW), .NUM_COLS(NC), .COUNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_piso  (rst_piso),
    .load      (load),
    .par_in    (par_in),
    .load_ready(load_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .beat_idx  (beat_idx),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one beat presented on the stream outputs.
  task automatic beat(input string tag, input logic [DW-1:0] d, input logic [CW-1:0] b,
                      input logic last);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".beat"},  32'(beat_idx),  32'(b));
    chk({tag, ".last"},  32'(out_last),  32'(last));
    chk({tag, ".busy"},  32'(busy),      32'd1);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".busy"},  32'(busy),      32'd0);
    chk({tag, ".last"},  32'(out_last),  32'd0);
  endtask

  initial begin
    rst_piso  = 1'b1;
    load      = 1'b0;
    par_in    = '0;
    out_ready = 1'b1;
    step();
    step();
    rst_piso = 1'b0;
    #1;
    // Reset state
    idle_chk("rst");
    chk("rst.data",    32'(out_data),   32'd0);
    chk("rst.beat",    32'(beat_idx),   32'd0);
    chk("rst.overrun", 32'(overrun),    32'd0);
    chk("rst.ready",   32'(load_ready), 32'd1);

    // Basic row
    load = 1'b1; par_in = ROW_A;
    step();
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      beat("basic", DW'(k), CW'(k - 1), k == 4);
      step();
    end
    idle_chk("basic.end");

    // Backpressure at beat 2
    load = 1'b1; par_in = ROW_A;
    step();
    load = 1'b0;
    beat("bp0", 16'h1, 4'd0, 1'b0);
    step();
    beat("bp1", 16'h2, 4'd1, 1'b0);
    step();
    beat("bp2", 16'h3, 4'd2, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      beat("bp.hold", 16'h3, 4'd2, 1'b0);
    end
    out_ready = 1'b1;
    step();
    beat("bp3", 16'h4, 4'd3, 1'b1);
    step();
    idle_chk("bp.end");

    // Back-to-back rows
    load = 1'b1; par_in = ROW_A;
    step();
    load = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      beat("b2b", DW'(k), CW'(k - 1), 1'b0);
      step();
    end
    beat("b2b4", 16'h4, 4'd3, 1'b1);
    load = 1'b1; par_in = ROW_B;
    #1;
    chk("b2b.ready", 32'(load_ready), 32'd1);
    step();
    load = 1'b0;
    for (int k = 5; k <= 8; k++) begin
      beat("b2b", DW'(k), CW'(k - 5), k == 8);
      step();
    end
    idle_chk("b2b.end");
    chk("b2b.overrun", 32'(overrun), 32'd0);

    // Mid-row load: overrun without the holding register, queued row with it
    load = 1'b1; par_in = ROW_A;
    step();
    load = 1'b0;
    beat("ovr1", 16'h1, 4'd0, 1'b0);
    load = 1'b1; par_in = ROW_B;
    #1;
`ifdef RESULT_PISO_HOLD_EN
    chk("hold.ready1", 32'(load_ready), 32'd1);
    step();
    load = 1'b0;
    chk("hold.overrun0", 32'(overrun), 32'd0);
    beat("hold2", 16'h2, 4'd1, 1'b0);
    load = 1'b1; par_in = ROW_C;
    #1;
    chk("hold.ready2", 32'(load_ready), 32'd0);
    step();
    load = 1'b0;
    chk("hold.overrun1", 32'(overrun), 32'd1);
    for (int k = 3; k <= 8; k++) begin
      beat("hold", DW'(k), CW'((k - 1) % 4), (k == 4) || (k == 8));
      step();
    end
    idle_chk("hold.end");
`else
    chk("ovr.ready", 32'(load_ready), 32'd0);
    step();
    load = 1'b0;
    chk("ovr.set", 32'(overrun), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      beat("ovr", DW'(k), CW'(k - 1), k == 4);
      step();
    end
    idle_chk("ovr.end");
`endif
    chk("ovr.sticky", 32'(overrun), 32'd1);

    // Reset mid-row discards the row and clears overrun
    load = 1'b1; par_in = ROW_A;
    step();
    load = 1'b0;
    beat("mr0", 16'h1, 4'd0, 1'b0);
    step();
    beat("mr1", 16'h2, 4'd1, 1'b0);
    rst_piso = 1'b1;
    step();
    rst_piso = 1'b0;
    idle_chk("mr.rst");
    chk("mr.overrun", 32'(overrun), 32'd0);
    step();
    idle_chk("mr.quiet");
    load = 1'b1; par_in = ROW_B;
    step();
    load = 1'b0;
    for (int k = 5; k <= 8; k++) begin
      beat("mr.new", DW'(k), CW'(k - 5), k == 8);
      step();
    end
    idle_chk("mr.end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
